// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer. Synchronizes the interrupt lines,
// arbitrates exceptions, interrupts and MRET at instruction boundaries, captures
// the CSR update values on trap entry, and drives a fixed
// trap/mret -> flush -> idle sequence.
module trap_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        ext_irq,
    input  logic        sw_irq,
    input  logic        tmr_irq,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic [31:0] exc_tval,
    input  logic [31:0] next_pc,
    input  logic        retire,
    input  logic        mret_req,
    input  logic [31:0] mstatus_cur,
    input  logic [31:0] mie_cur,
    output logic        trap,
    output logic        mret,
    output logic [31:0] mepc,
    output logic [31:0] mstatus_new,
    output logic [31:0] mip_new,
    output logic [31:0] mcause,
    output logic [31:0] mtval,
    output logic        stall,
    output logic        flush
);

    typedef enum logic [1:0] {IDLE, TRAP, MRET, REDIR} state_t;

    state_t      state_q, state_d;
    // Interrupt lines packed as {ext, sw, tmr}.
    logic [2:0]  irq_meta_q, irq_meta_d;
    logic [2:0]  irq_sync_q, irq_sync_d;
    logic [2:0]  pend;
    logic [4:0]  irq_code;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [31:0] mstatus_new_q, mstatus_new_d;
    logic [31:0] mip_new_q, mip_new_d;
    logic [31:0] mstatus_trap;
    logic [31:0] mip_snapshot;
    logic        unused_bits;

    // Low PC bits and non-machine-interrupt enable bits carry no meaning here.
    assign unused_bits = &{1'b0, exc_pc[1:0], next_pc[1:0], mie_cur};

    // Two-flop synchronizer input stage.
    always_comb begin
        irq_meta_d = {ext_irq, sw_irq, tmr_irq};
        irq_sync_d = irq_meta_q;
    end

    // Pending-and-enabled interrupts, gated by global MIE; MEI wins, then MSI, then MTI.
    always_comb begin
        pend = irq_sync_q & {mie_cur[11], mie_cur[3], mie_cur[7]} & {3{mstatus_cur[3]}};
        if (pend[2])      irq_code = 5'd11;
        else if (pend[1]) irq_code = 5'd3;
        else              irq_code = 5'd7;
        // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
        mstatus_trap = {mstatus_cur[31:13], 2'b11, mstatus_cur[10:8], mstatus_cur[3],
                        mstatus_cur[6:4], 1'b0, mstatus_cur[2:0]};
        mip_snapshot = {20'b0, irq_sync_q[2], 3'b0, irq_sync_q[0], 3'b0, irq_sync_q[1], 3'b0};
    end

    // Next-state, capture values and outputs; requests are only looked at in IDLE.
    always_comb begin
        state_d       = state_q;
        mepc_d        = mepc_q;
        mcause_d      = mcause_q;
        mtval_d       = mtval_q;
        mstatus_new_d = mstatus_new_q;
        mip_new_d     = mip_new_q;
        case (state_q)
            IDLE: begin
                if (exc_valid) begin
                    state_d       = TRAP;
                    mepc_d        = {exc_pc[31:2], 2'b00};
                    mcause_d      = {27'b0, exc_code};
                    mtval_d       = exc_tval;
                    mstatus_new_d = mstatus_trap;
                    mip_new_d     = mip_snapshot;
                end else if (retire && (|pend)) begin
                    state_d       = TRAP;
                    mepc_d        = {next_pc[31:2], 2'b00};
                    mcause_d      = {1'b1, 26'b0, irq_code};
                    mtval_d       = 32'b0;
                    mstatus_new_d = mstatus_trap;
                    mip_new_d     = mip_snapshot;
                end else if (mret_req) begin
                    state_d = MRET;
                end
            end
            TRAP:    state_d = REDIR;
            MRET:    state_d = REDIR;
            REDIR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        trap  = (state_q == TRAP);
        mret  = (state_q == MRET);
        flush = (state_q == REDIR);
        // Held low while reset is asserted so a pending request cannot stall the core.
        stall = !rst && ((state_q != IDLE) || (state_d != IDLE));
    end

    // State, synchronizer and capture registers; reset acts immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            irq_meta_q    <= '0;
            irq_sync_q    <= '0;
            mepc_q        <= '0;
            mcause_q      <= '0;
            mtval_q       <= '0;
            mstatus_new_q <= '0;
            mip_new_q     <= '0;
        end else begin
            state_q       <= state_d;
            irq_meta_q    <= irq_meta_d;
            irq_sync_q    <= irq_sync_d;
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
            mtval_q       <= mtval_d;
            mstatus_new_q <= mstatus_new_d;
            mip_new_q     <= mip_new_d;
        end
    end

    assign mepc        = mepc_q;
    assign mcause      = mcause_q;
    assign mtval       = mtval_q;
    assign mstatus_new = mstatus_new_q;
    assign mip_new     = mip_new_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed cycle table, hand-written latency/masking
// sequences, then randomized traffic against a behavioural model.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst, ext_irq, sw_irq, tmr_irq, exc_valid, retire, mret_req;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc, exc_tval, next_pc, mstatus_cur, mie_cur;
    logic        trap, mret, stall, flush;
    logic [31:0] mepc, mstatus_new, mip_new, mcause, mtval;

    int n_vec  = 0;
    int n_miss = 0;

    trap_ctrl dut (
        .clk(clk), .rst(rst), .ext_irq(ext_irq), .sw_irq(sw_irq), .tmr_irq(tmr_irq),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_tval(exc_tval),
        .next_pc(next_pc), .retire(retire), .mret_req(mret_req),
        .mstatus_cur(mstatus_cur), .mie_cur(mie_cur),
        .trap(trap), .mret(mret), .mepc(mepc), .mstatus_new(mstatus_new),
        .mip_new(mip_new), .mcause(mcause), .mtval(mtval), .stall(stall), .flush(flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ev;
        logic [4:0]  code;
        logic [31:0] pc;
        logic [31:0] tval;
        logic        mr;
        logic        ret;
        logic [2:0]  irq;     // {ext, sw, tmr}
        logic [31:0] npc;
        logic [3:0]  strb;    // {trap, mret, flush, stall}
        logic [31:0] e_mepc;
        logic [31:0] e_mcause;
        logic [31:0] e_mtval;
        logic [31:0] e_mip;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic ev, input logic [4:0] code,
                                input logic [31:0] pc, input logic [31:0] tval,
                                input logic mr, input logic ret, input logic [2:0] irq,
                                input logic [31:0] npc, input logic [3:0] strb,
                                input logic [31:0] em, input logic [31:0] ec,
                                input logic [31:0] et, input logic [31:0] ei);
        vec_t v;
        v.rst = r; v.ev = ev; v.code = code; v.pc = pc; v.tval = tval; v.mr = mr;
        v.ret = ret; v.irq = irq; v.npc = npc; v.strb = strb;
        v.e_mepc = em; v.e_mcause = ec; v.e_mtval = et; v.e_mip = ei;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        exc_valid = 0; exc_code = 0; exc_pc = 0; exc_tval = 0; retire = 0;
        mret_req = 0; next_pc = 0; {ext_irq, sw_irq, tmr_irq} = 3'b000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        idle_inputs();
        @(negedge clk);
        rst = 0;
    endtask

    // Behavioural model state: remaining cycles of the current sequence and its kind.
    int          busy;
    int          kind;          // 1 = trap, 2 = mret
    logic [2:0]  hist[$];       // irq values seen at past clock edges
    logic [31:0] m_mepc, m_mcause, m_mtval, m_mstn, m_mip;

    function automatic void model_reset();
        busy = 0; kind = 0;
        m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mstn = 0; m_mip = 0;
        hist.delete();
        hist.push_back(3'b000);
        hist.push_back(3'b000);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int seen;
        logic [4:0] legal [6];
        rst = 1;
        mstatus_cur = 32'h1808;
        mie_cur     = 32'h888;
        idle_inputs();

        // rst ev code pc tval mr ret irq npc strb mepc mcause mtval mip
        add(1,0,0,0,0,0,0,3'b000,0,4'b0000, 0,0,0,0);
        add(0,1,2,32'h104,32'hDEADBEEF,0,0,3'b000,0,4'b0001, 0,0,0,0);
        add(0,1,2,32'h104,32'hDEADBEEF,0,0,3'b000,0,4'b1001, 32'h104,2,32'hDEADBEEF,0);
        add(0,0,0,0,0,0,0,3'b000,0,4'b0011, 32'h104,2,32'hDEADBEEF,0);
        add(0,0,0,0,0,0,0,3'b000,0,4'b0000, 32'h104,2,32'hDEADBEEF,0);
        add(0,0,0,0,0,0,0,3'b111,0,4'b0000, 32'h104,2,32'hDEADBEEF,0);
        add(0,0,0,0,0,0,0,3'b111,0,4'b0000, 32'h104,2,32'hDEADBEEF,0);
        add(0,1,8,32'h300,0,0,1,3'b111,32'h400,4'b0001, 32'h104,2,32'hDEADBEEF,0);
        add(0,1,8,32'h300,0,0,1,3'b111,32'h400,4'b1001, 32'h300,8,0,32'h888);
        add(0,0,0,0,0,0,1,3'b111,32'h400,4'b0011, 32'h300,8,0,32'h888);
        add(0,0,0,0,0,0,1,3'b111,32'h400,4'b0001, 32'h300,8,0,32'h888);
        add(0,0,0,0,0,0,1,3'b111,32'h400,4'b1001, 32'h400,32'h8000000B,0,32'h888);
        add(0,0,0,0,0,0,0,3'b000,0,4'b0011, 32'h400,32'h8000000B,0,32'h888);
        add(0,0,0,0,0,0,0,3'b000,0,4'b0000, 32'h400,32'h8000000B,0,32'h888);
        add(0,0,0,0,0,0,0,3'b000,0,4'b0000, 32'h400,32'h8000000B,0,32'h888);
        add(0,0,0,0,0,0,0,3'b000,0,4'b0000, 32'h400,32'h8000000B,0,32'h888);
        add(0,0,0,0,0,1,0,3'b000,0,4'b0001, 32'h400,32'h8000000B,0,32'h888);
        add(0,0,0,0,0,1,0,3'b000,0,4'b0101, 32'h400,32'h8000000B,0,32'h888);
        add(0,0,0,0,0,0,0,3'b000,0,4'b0011, 32'h400,32'h8000000B,0,32'h888);
        add(0,0,0,0,0,0,0,3'b000,0,4'b0000, 32'h400,32'h8000000B,0,32'h888);
        add(0,1,4,32'h507,32'h507,1,0,3'b000,0,4'b0001, 32'h400,32'h8000000B,0,32'h888);
        add(0,1,4,32'h507,32'h507,1,0,3'b000,0,4'b1001, 32'h504,4,32'h507,0);
        add(0,0,0,0,0,0,0,3'b000,0,4'b0011, 32'h504,4,32'h507,0);
        add(0,0,0,0,0,0,0,3'b000,0,4'b0000, 32'h504,4,32'h507,0);
        add(0,1,6,32'h600,32'h11,0,0,3'b000,0,4'b0001, 32'h504,4,32'h507,0);
        add(0,1,6,32'h600,32'h11,0,0,3'b000,0,4'b1001, 32'h600,6,32'h11,0);
        add(1,1,6,32'h600,32'h11,0,0,3'b000,0,4'b0000, 0,0,0,0);
        add(0,1,6,32'h600,32'h11,0,0,3'b000,0,4'b0001, 0,0,0,0);
        add(0,1,6,32'h600,32'h11,0,0,3'b000,0,4'b1001, 32'h600,6,32'h11,0);
        add(0,0,0,0,0,0,0,3'b000,0,4'b0011, 32'h600,6,32'h11,0);
        add(0,0,0,0,0,0,0,3'b000,0,4'b0000, 32'h600,6,32'h11,0);

        // Directed cycle table: drive on the falling edge, compare just after.
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst = tbl[i].rst; exc_valid = tbl[i].ev; exc_code = tbl[i].code;
            exc_pc = tbl[i].pc; exc_tval = tbl[i].tval; mret_req = tbl[i].mr;
            retire = tbl[i].ret; {ext_irq, sw_irq, tmr_irq} = tbl[i].irq;
            next_pc = tbl[i].npc;
            #1;
            check($sformatf("row%0d.strobes", i), {28'b0, trap, mret, flush, stall}, {28'b0, tbl[i].strb});
            check($sformatf("row%0d.mepc", i), mepc, tbl[i].e_mepc);
            check($sformatf("row%0d.mcause", i), mcause, tbl[i].e_mcause);
            check($sformatf("row%0d.mtval", i), mtval, tbl[i].e_mtval);
            check($sformatf("row%0d.mip_new", i), mip_new, tbl[i].e_mip);
            $display("row %0d: strb=%b mepc=%h mcause=%h", i, {trap, mret, flush, stall}, mepc, mcause);
        end

        // Timer interrupt latency: line rises, trap appears on the third edge.
        do_reset();
        mstatus_cur = 32'h1808; mie_cur = 32'h80; retire = 1; next_pc = 32'h200;
        @(negedge clk);
        tmr_irq = 1;
        n = 1;
        while (n <= 10) begin
            @(negedge clk); #1;
            if (trap) break;
            n++;
        end
        check("timer.latency", n, 3);
        check("timer.mcause", mcause, 32'h80000007);
        check("timer.mepc", mepc, 32'h200);
        check("timer.mstatus_new", mstatus_new, 32'h1880);
        check("timer.mip_new", mip_new, 32'h80);
        $display("timer: latency=%0d mcause=%h mstatus_new=%h", n, mcause, mstatus_new);

        // Masking: global MIE clear keeps the timer pending indefinitely.
        do_reset();
        mstatus_cur = 32'h1800; mie_cur = 32'h80; retire = 1; next_pc = 32'h240; tmr_irq = 1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #1;
            if (trap || stall) seen++;
        end
        check("mask.no_trap", seen, 0);
        @(negedge clk);
        mstatus_cur = 32'h1808;
        #1;
        check("mask.stall_on_enable", {31'b0, stall}, 1);
        @(negedge clk); #1;
        check("mask.trap", {31'b0, trap}, 1);
        check("mask.mcause", mcause, 32'h80000007);
        check("mask.mepc", mepc, 32'h240);
        $display("mask: held-off cycles with activity=%0d trap=%b", seen, trap);

        // MRET stall length: exactly three stalled cycles.
        do_reset();
        mstatus_cur = 32'h1808; mie_cur = 32'h888;
        @(negedge clk);
        mret_req = 1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (stall) seen++;
            @(negedge clk);
            if (c == 1) mret_req = 0;
        end
        check("mret.stall_cycles", seen, 3);
        $display("mret: stall cycles=%0d", seen);

        // Randomized traffic against the behavioural model.
        do_reset();
        model_reset();
        legal = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd6, 5'd8};
        for (int c = 0; c < 3000; c++) begin
            logic [2:0] s;
            logic pe, ps, pt, idle, go_exc, go_irq, go_mret;
            logic e_trap, e_mret, e_flush, e_stall;
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            exc_valid = ($urandom_range(0, 7) == 0);
            exc_code  = ($urandom_range(0, 9) == 0) ? 5'($urandom) : legal[$urandom_range(0, 5)];
            exc_pc = $urandom; exc_tval = $urandom; next_pc = $urandom;
            retire = $urandom_range(0, 1) == 1;
            mret_req = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) ext_irq = ~ext_irq;
            if ($urandom_range(0, 15) == 0) sw_irq  = ~sw_irq;
            if ($urandom_range(0, 15) == 0) tmr_irq = ~tmr_irq;
            mstatus_cur = $urandom; mie_cur = $urandom;
            #1;
            if (rst) model_reset();
            s    = hist[0];
            pe   = s[2] && mie_cur[11] && mstatus_cur[3];
            ps   = s[1] && mie_cur[3]  && mstatus_cur[3];
            pt   = s[0] && mie_cur[7]  && mstatus_cur[3];
            idle = (busy == 0) && !rst;
            go_exc  = idle && exc_valid;
            go_irq  = idle && !exc_valid && retire && (pe || ps || pt);
            go_mret = idle && !exc_valid && !go_irq && mret_req;
            e_trap  = (busy == 2) && (kind == 1);
            e_mret  = (busy == 2) && (kind == 2);
            e_flush = (busy == 1);
            e_stall = (busy != 0) || go_exc || go_irq || go_mret;
            check($sformatf("rnd%0d.strobes", c), {28'b0, trap, mret, flush, stall},
                  {28'b0, e_trap, e_mret, e_flush, e_stall});
            check($sformatf("rnd%0d.mepc", c), mepc, m_mepc);
            check($sformatf("rnd%0d.mcause", c), mcause, m_mcause);
            check($sformatf("rnd%0d.mtval", c), mtval, m_mtval);
            check($sformatf("rnd%0d.mstatus_new", c), mstatus_new, m_mstn);
            check($sformatf("rnd%0d.mip_new", c), mip_new, m_mip);
            $display("rnd %0d: rst=%b strb=%b mcause=%h", c, rst, {trap, mret, flush, stall}, mcause);
            // Effect of the coming rising edge.
            if (!rst) begin
                if (go_exc || go_irq) begin
                    m_mstn = (mstatus_cur & ~32'h1888) | 32'h1800 | (mstatus_cur[3] ? 32'h80 : 32'h0);
                    m_mip  = (s[2] ? 32'h800 : 32'h0) | (s[0] ? 32'h80 : 32'h0) | (s[1] ? 32'h8 : 32'h0);
                end
                if (busy > 0) begin
                    busy--;
                end else if (go_exc) begin
                    busy = 2; kind = 1;
                    m_mepc = exc_pc & ~32'h3; m_mcause = {27'b0, exc_code}; m_mtval = exc_tval;
                end else if (go_irq) begin
                    busy = 2; kind = 1;
                    m_mepc = next_pc & ~32'h3; m_mtval = 0;
                    m_mcause = 32'h80000000 + (pe ? 32'd11 : (ps ? 32'd3 : 32'd7));
                end else if (go_mret) begin
                    busy = 2; kind = 2;
                end
                hist.push_back({ext_irq, sw_irq, tmr_irq});
                void'(hist.pop_front());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
